// File: rtl/dpd_gain_apply_pkg.sv
// ---------------------------------------------------------------------------
// dpd_gain_apply_pkg
// Shared DPD types, constants and fixed-point helpers.
//   s18 / s20 / u20 / u40 : sample, coefficient and magnitude word types
//   COEF_ONE              : coefficient unity (2^14)
//   MAG_ONE               : magnitude unity (2^19 - 1, full-scale |x|^0)
//   LAT                   : input-to-output latency in clk cycles
// ---------------------------------------------------------------------------
package dpd_gain_apply_pkg;

    typedef logic signed [17:0] s18;
    typedef logic signed [19:0] s20;
    typedef logic        [19:0] u20;
    typedef logic        [39:0] u40;

    localparam int LAT      = 6;
    localparam int NTAP     = 5;
    localparam int COEF_ONE = 16384;
    localparam int MAG_ONE  = 524287;

    localparam s18 S18_MAX = s18'(131071);
    localparam s18 S18_MIN = s18'(-131072);
    localparam s20 S20_MAX = s20'(524287);
    localparam s20 S20_MIN = s20'(-524288);

    typedef struct packed {
        s18 re;
        s18 im;
    } coef_t;

    localparam coef_t COEF_UNITY = '{re: s18'(COEF_ONE), im: s18'(0)};
    localparam coef_t COEF_ZERO  = '{re: s18'(0), im: s18'(0)};

    // c * |x|^k at full width, then >> 19 with half-up rounding.
    // The magnitude is zero-extended so the multiply stays signed.
    function automatic s20 rnd_mag_prod(input s18 c, input u20 m);
        return s20'((39'(c) * 39'($signed({1'b0, m})) + 39'sd262144) >>> 19);
    endfunction

    function automatic s18 sat_gain(input logic signed [22:0] v);
        if (v > 23'(S18_MAX))
            return S18_MAX;
        else if (v < 23'(S18_MIN))
            return S18_MIN;
        else
            return s18'(v);
    endfunction

    function automatic logic clip_out(input logic signed [24:0] v);
        return (v > 25'(S20_MAX)) || (v < 25'(S20_MIN));
    endfunction

    function automatic s20 sat_out(input logic signed [24:0] v);
        if (v > 25'(S20_MAX))
            return S20_MAX;
        else if (v < 25'(S20_MIN))
            return S20_MIN;
        else
            return s20'(v);
    endfunction

endpackage

// File: rtl/dpd_gain_apply_delay_rg.sv
// ---------------------------------------------------------------------------
// delay_rg
// Fixed D-cycle register delay line, async active-low reset to zero.
//   clk     : clock
//   reset_b : async active-low reset
//   d_i     : W-bit input word
//   q_o     : d_i delayed by D rising edges
// ---------------------------------------------------------------------------
module delay_rg #(
    parameter int W = 20,
    parameter int D = 3
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sr_q [D];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < D; i++)
                sr_q[i] <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < D; i++)
                sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[D-1];

endmodule

// File: rtl/dpd_gain_apply.sv
// ---------------------------------------------------------------------------
// dpd_gain_apply
// Memory-polynomial style gain: G = sum_k c_k * |x|^k, y = G * x.
// Streams one sample per cycle with a fixed 6-cycle latency.
//   clk, reset_b            : clock, async active-low reset
//   sig_in_i/q  (s20)       : complex input sample
//   mag_0..mag_4 (u20)      : |x|^k for the same sample, 2^19 = 1.0
//   coef_we/addr/re/im      : shadow coefficient bank write (addr 0..4)
//   coef_swap               : copy shadow bank into active bank
//   sat_clr                 : clear sat_sticky
//   sig_out_i/q (s20)       : predistorted sample
//   sat_pulse / sat_sticky  : output clip flag / latched clip flag
// ---------------------------------------------------------------------------
module dpd_gain_apply
    import dpd_gain_apply_pkg::*;
(
    input  logic               clk,
    input  logic               reset_b,
    input  logic signed [19:0] sig_in_i,
    input  logic signed [19:0] sig_in_q,
    input  logic        [19:0] mag_0,
    input  logic        [19:0] mag_1,
    input  logic        [19:0] mag_2,
    input  logic        [19:0] mag_3,
    input  logic        [19:0] mag_4,
    input  logic               coef_we,
    input  logic        [2:0]  coef_addr,
    input  logic signed [17:0] coef_re,
    input  logic signed [17:0] coef_im,
    input  logic               coef_swap,
    input  logic               sat_clr,
    output logic signed [19:0] sig_out_i,
    output logic signed [19:0] sig_out_q,
    output logic               sat_pulse,
    output logic               sat_sticky
);

    coef_t shadow_q [NTAP];
    coef_t active_q [NTAP];
    coef_t coef_eff [NTAP];
    u20    mag      [NTAP];

    s20                 prod_re_d [NTAP];
    s20                 prod_im_d [NTAP];
    s20                 prod_re_q [NTAP];
    s20                 prod_im_q [NTAP];
    logic signed [20:0] pair_re_q [3];
    logic signed [20:0] pair_im_q [3];
    s18                 gain_re_q;
    s18                 gain_im_q;
    logic signed [37:0] cp_q      [4];
    logic signed [24:0] yacc_i_d, yacc_q_d;
    logic signed [24:0] yacc_i_q, yacc_q_q;
    s20                 y_i_d, y_q_d;
    s20                 y_i_q, y_q_q;
    logic               sat_pulse_d, sat_pulse_q;
    logic               sat_sticky_d, sat_sticky_q;
    s20                 xd_i, xd_q;

    // Coefficient banks. The swap copies the pre-write shadow, so a
    // write in the swap cycle lands in the shadow bank only.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int k = 0; k < NTAP; k++) begin
                shadow_q[k] <= (k == 0) ? COEF_UNITY : COEF_ZERO;
                active_q[k] <= (k == 0) ? COEF_UNITY : COEF_ZERO;
            end
        end else begin
            if (coef_we && (coef_addr <= 3'd4))
                shadow_q[coef_addr] <= '{re: coef_re, im: coef_im};
            if (coef_swap)
                active_q <= shadow_q;
        end
    end

    // The sample captured on the swap edge must already see the new
    // bank, so S1 looks through to the shadow bank during a swap.
    always_comb begin
        mag[0] = mag_0;
        mag[1] = mag_1;
        mag[2] = mag_2;
        mag[3] = mag_3;
        mag[4] = mag_4;
        for (int k = 0; k < NTAP; k++) begin
            coef_eff[k]  = coef_swap ? shadow_q[k] : active_q[k];
            prod_re_d[k] = rnd_mag_prod(coef_eff[k].re, mag[k]);
            prod_im_d[k] = rnd_mag_prod(coef_eff[k].im, mag[k]);
        end
    end

    // Align x with G: G is registered at S3, used at S4.
    delay_rg #(.W(20), .D(3)) u_dly_i (
        .clk     (clk),
        .reset_b (reset_b),
        .d_i     (sig_in_i),
        .q_o     (xd_i)
    );

    delay_rg #(.W(20), .D(3)) u_dly_q (
        .clk     (clk),
        .reset_b (reset_b),
        .d_i     (sig_in_q),
        .q_o     (xd_q)
    );

    // Complex multiply, then round half-up by 2^14.
    always_comb begin
        yacc_i_d = 25'((39'(cp_q[0]) - 39'(cp_q[1]) + 39'sd8192) >>> 14);
        yacc_q_d = 25'((39'(cp_q[2]) + 39'(cp_q[3]) + 39'sd8192) >>> 14);
        y_i_d        = sat_out(yacc_i_q);
        y_q_d        = sat_out(yacc_q_q);
        sat_pulse_d  = clip_out(yacc_i_q) | clip_out(yacc_q_q);
        // Set takes priority over clear.
        sat_sticky_d = sat_pulse_d | (sat_sticky_q & ~sat_clr);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int k = 0; k < NTAP; k++) begin
                prod_re_q[k] <= '0;
                prod_im_q[k] <= '0;
            end
            for (int p = 0; p < 3; p++) begin
                pair_re_q[p] <= '0;
                pair_im_q[p] <= '0;
            end
            for (int j = 0; j < 4; j++)
                cp_q[j] <= '0;
            gain_re_q    <= '0;
            gain_im_q    <= '0;
            yacc_i_q     <= '0;
            yacc_q_q     <= '0;
            y_i_q        <= '0;
            y_q_q        <= '0;
            sat_pulse_q  <= 1'b0;
            sat_sticky_q <= 1'b0;
        end else begin
            // S1
            prod_re_q <= prod_re_d;
            prod_im_q <= prod_im_d;
            // S2
            pair_re_q[0] <= 21'(prod_re_q[0]) + 21'(prod_re_q[1]);
            pair_re_q[1] <= 21'(prod_re_q[2]) + 21'(prod_re_q[3]);
            pair_re_q[2] <= 21'(prod_re_q[4]);
            pair_im_q[0] <= 21'(prod_im_q[0]) + 21'(prod_im_q[1]);
            pair_im_q[1] <= 21'(prod_im_q[2]) + 21'(prod_im_q[3]);
            pair_im_q[2] <= 21'(prod_im_q[4]);
            // S3: 23-bit sum keeps 3 guard bits over s20 terms
            gain_re_q <= sat_gain(23'(pair_re_q[0]) + 23'(pair_re_q[1]) + 23'(pair_re_q[2]));
            gain_im_q <= sat_gain(23'(pair_im_q[0]) + 23'(pair_im_q[1]) + 23'(pair_im_q[2]));
            // S4
            cp_q[0] <= 38'(gain_re_q) * 38'(xd_i);
            cp_q[1] <= 38'(gain_im_q) * 38'(xd_q);
            cp_q[2] <= 38'(gain_re_q) * 38'(xd_q);
            cp_q[3] <= 38'(gain_im_q) * 38'(xd_i);
            // S5
            yacc_i_q <= yacc_i_d;
            yacc_q_q <= yacc_q_d;
            // S6
            y_i_q        <= y_i_d;
            y_q_q        <= y_q_d;
            sat_pulse_q  <= sat_pulse_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

    assign sig_out_i  = y_i_q;
    assign sig_out_q  = y_q_q;
    assign sat_pulse  = sat_pulse_q;
    assign sat_sticky = sat_sticky_q;

endmodule

// File: doc/dpd_gain_apply.md
DPD_GAIN_APPLY -- requirements
Module: dpd_gain_apply

Interface
REQ-001 Parameter LAT, default 6, fixed input-to-output latency in clk cycles; not overridable.
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 reset_b  in  1  reset; asynchronous, active-low.
REQ-004 sig_in_i, sig_in_q  in  s20 each  complex sample, aligned with mag_0..mag_4 of the same cycle.
REQ-005 mag_0..mag_4  in  u20 each  |x|^k, k=0..4, scale 2^19 = 1.0.
REQ-006 coef_we  in  1  shadow-bank write strobe.
REQ-007 coef_addr  in  3  coefficient index; 0..4 valid.
REQ-008 coef_re, coef_im  in  s18 each  coefficient, scale 2^14 = 1.0.
REQ-009 coef_swap  in  1  one-cycle request to copy shadow bank into active bank.
REQ-010 sat_clr  in  1  clears sat_sticky.
REQ-011 sig_out_i, sig_out_q  out  s20 each  predistorted sample.
REQ-012 sat_pulse  out  1  high for the cycle whose output saturated.
REQ-013 sat_sticky  out  1  latched OR of sat_pulse.

Function
REQ-014 Block SHALL stream one sample per cycle, no stall, no valid.
REQ-015 Gain SHALL be G = sum_k c_k * mag_k, with c_k taken from the active bank.
REQ-016 Each real product s18 x u20 SHALL be formed at full width, then shifted right 19 bits, rounding half-up (add bit 18).
REQ-017 The 5-term sum SHALL carry 3 guard bits, then saturate to s18 per component.
REQ-018 Output SHALL be y = G * x, where re = Gr*xi - Gi*xq and im = Gr*xq + Gi*xi.
REQ-019 Each y component SHALL be computed at full width, shifted right 14 bits with half-up rounding, then saturated to [-524288, 524287].
REQ-020 Pipeline stages:
- S1: products registered
- S2: pair sums
- S3: final sum and gain saturation
- S4: complex products
- S5: add/sub and round
- S6: saturate into output registers
REQ-021 Input sample at edge n SHALL appear on the outputs after edge n+6; sig_in SHALL be delayed 3 cycles internally to meet G at S4.
REQ-022 coef_we with coef_addr <= 4 SHALL write the shadow bank at that edge; coef_addr 5..7 SHALL be ignored.
REQ-023 coef_swap SHALL update all 5 active coefficients at the same edge, never partially.
REQ-024 Samples entering S1 at or after the swap edge SHALL use the new bank; samples already in flight SHALL finish with the old bank.
REQ-025 coef_we and coef_swap in the same cycle: the active bank SHALL take the pre-write shadow contents; the write SHALL land in shadow only.
REQ-026 sat_pulse SHALL be 1 when either output component clipped, aligned with that output.
REQ-027 sat_sticky SHALL set on sat_pulse.
REQ-028 When sat_clr and sat_pulse occur together, set SHALL win.

Reset
REQ-029 On reset_b low, all pipeline registers, sig_out_i/q, sat_pulse and sat_sticky SHALL go to 0 immediately.
REQ-030 On reset, both banks SHALL load c0 = (16384, 0) and c1..c4 = 0, giving identity transfer.
REQ-031 Reset mid-stream SHALL discard in-flight samples; the first valid output SHALL come 6 cycles after release.

Structure
REQ-032 Types s18, s20, u20, u40 and constants COEF_ONE = 16384, MAG_ONE = 524287, LAT = 6 SHALL live in the shared DPD package.
REQ-033 The input alignment delay SHALL use the existing delay_rg sub-module (W = 20, D = 3), one instance per I and Q.

Verification
REQ-034 Post-reset identity: x = (100000, -50000), mag_0 = 524287, others random -> y = (100000, -50000) at n+6, sat_pulse = 0.
REQ-035 Shadow isolation then swap:
- write c1 = (16384, 0), no swap; x = (100000, 0), mag_1 = 262144 -> y = (100000, 0).
- pulse coef_swap -> y = (150000, 0) from the first post-swap sample.
REQ-036 Rotation: c0 = (0, 16384), x = (1000, 2000) -> y = (-2000, 1000).
REQ-037 Saturation:
- c0 = (131071, 0), x = (200000, -200000) -> y = (524287, -524288), sat_pulse = 1, sat_sticky = 1.
- sat_clr -> sat_sticky = 0 on the next clean cycle.
REQ-038 Same-cycle write + swap: write c0 = (8192, 0) together with coef_swap, from the identity state -> output unchanged; a second swap -> y = x/2.
REQ-039 Reset pulse mid-stream -> outputs 0 asynchronously, banks back to identity, correct identity output 6 cycles after release.
